// File: rtl/shift_arbiter_pkg.sv
// Shared types for the rotate arbiter: rotate direction and the default command layout.
package shift_arb_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic {ROT_LEFT = 1'b0, ROT_RIGHT = 1'b1} rot_dir_t;

  typedef struct packed {
    logic [31:0] num;
    logic [4:0]  amt;
    rot_dir_t    dir;
  } shift_cmd_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the command sources (master) and the arbiter (slave).
interface shift_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  localparam int AMT_W = $clog2(DATA_W);
  localparam int ID_W  = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_num;
  logic [NREQ*AMT_W-1:0]  req_amt;
  logic [NREQ-1:0]        req_lr;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_W-1:0]      resp_data;
  logic [ID_W-1:0]        resp_id;

  modport master (
    output req_valid, req_num, req_amt, req_lr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_num, req_amt, req_lr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/shift_arbiter_rr_grant.sv
// Combinational round-robin picker: lowest requester above last_grant wins, else lowest overall.
module rr_grant #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] grant_idx_o,
  output logic            grant_any_o
);

  logic [NREQ-1:0] upper_req;
  logic [NREQ-1:0] pick;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign upper_req[gi] = req_i[gi] && (ID_W'(gi) > last_grant_i);
  end

  assign pick = (|upper_req) ? upper_req : req_i;

  // Descending scan so the lowest set bit of pick is the one left standing.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant_o     = '0;
        grant_o[i]  = 1'b1;
        grant_idx_o = ID_W'(i);
        grant_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one registered rotate stage among NREQ requesters.
// Optional SHIFT_ARB_PERF_EN adds a saturating 16-bit stall_cnt output.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  shift_arbiter_if.slave bus
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int AMT_W = $clog2(DATA_W);
  localparam int ID_W  = $clog2(NREQ);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

  slot_t             state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;

  logic [NREQ-1:0]   gnt_onehot;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              can_accept;
  logic [NREQ-1:0]   req_ready;
  logic              fire;

  rr_grant #(.NREQ(NREQ), .ID_W(ID_W)) u_grant (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (gnt_onehot),
    .grant_idx_o  (gnt_idx),
    .grant_any_o  (gnt_any)
  );

  assign can_accept = (state_q == SLOT_EMPTY) || bus.resp_ready;
  assign req_ready  = rst ? '0 : (gnt_onehot & {NREQ{can_accept}});
  assign fire       = gnt_any && can_accept && !rst;

  // AND-OR payload mux keyed by the one-hot grant.
  logic [DATA_W-1:0] sel_num;
  logic [AMT_W-1:0]  sel_amt;
  logic              sel_lr;

  always_comb begin
    sel_num = '0;
    sel_amt = '0;
    sel_lr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_num = sel_num | bus.req_num[i*DATA_W +: DATA_W];
        sel_amt = sel_amt | bus.req_amt[i*AMT_W +: AMT_W];
        sel_lr  = sel_lr  | bus.req_lr[i];
      end
    end
  end

  // One mux stage per amount bit; stage gi rotates by 2**gi in the selected direction.
  logic [AMT_W:0][DATA_W-1:0] rot_stage;
  assign rot_stage[0] = sel_num;

  for (genvar gi = 0; gi < AMT_W; gi++) begin : g_rot
    localparam int S = 1 << gi;
    logic [DATA_W-1:0] rot_l, rot_r;
    assign rot_l = {rot_stage[gi][DATA_W-1-S:0], rot_stage[gi][DATA_W-1:DATA_W-S]};
    assign rot_r = {rot_stage[gi][S-1:0], rot_stage[gi][DATA_W-1:S]};
    assign rot_stage[gi+1] = !sel_amt[gi] ? rot_stage[gi]
                           : ((rot_dir_t'(sel_lr) == ROT_RIGHT) ? rot_r : rot_l);
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (fire) begin
      state_d      = SLOT_FULL;
      data_d       = rot_stage[AMT_W];
      id_d         = gnt_idx;
      last_grant_d = gnt_idx;
    end else if (state_q == SLOT_FULL && bus.resp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SLOT_EMPTY;
      data_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == SLOT_FULL);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;

`ifdef SHIFT_ARB_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == SLOT_FULL && !bus.resp_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_shift_arbiter;
  import shift_arb_pkg::*;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

`ifdef SHIFT_ARB_PERF_EN
  logic [15:0] stall_cnt;
  shift_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt)
  );
`else
  shift_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;
  int          m_ptr;
  int          m_cnt;
  bit          m_fire;
  int          m_win;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotation by arithmetic on a doubled word.
  function automatic logic [31:0] rot_ref(input logic [31:0] x, input int a, input bit right);
    logic [63:0] d;
    logic [63:0] t;
    int sh;
    d  = {x, x};
    sh = right ? a : ((32 - a) % 32);
    t  = d >> sh;
    return t[31:0];
  endfunction

  task automatic set_req(input int i, input logic v, input shift_cmd_t c);
    bus.req_valid[i]          = v;
    bus.req_num[i*32 +: 32]   = c.num;
    bus.req_amt[i*5 +: 5]     = c.amt;
    bus.req_lr[i]             = c.dir;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next edge.
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    int w;
    w = -1;
    if (!rst && (!m_valid || bus.resp_ready)) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (bus.req_valid[j] && w < 0) w = j;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    #3;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    @(posedge clk);
    m_fire = (w >= 0);
    m_win  = w;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = NREQ - 1; m_cnt = 0;
    end else begin
      if (m_valid && !bus.resp_ready && m_cnt != 16'hFFFF) m_cnt++;
      if (w >= 0) begin
        m_data  = rot_ref(bus.req_num[w*32 +: 32], int'(bus.req_amt[w*5 +: 5]), bus.req_lr[w]);
        m_id    = w;
        m_valid = 1'b1;
        m_ptr   = w;
        $display("txn: req %0d -> data %08h", w, m_data);
      end else if (bus.resp_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
    chk("resp_data",  64'(bus.resp_data),  64'(m_data));
    chk("resp_id",    64'(bus.resp_id),    64'(m_id));
`ifdef SHIFT_ARB_PERF_EN
    chk("stall_cnt",  64'(stall_cnt),      64'(m_cnt));
`endif
  endtask

  typedef struct {
    int          id;
    shift_cmd_t  cmd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   rr_seq[6];
  int   wrap_seq[3];

  initial begin
    shift_cmd_t c;

    vecs[0] = '{0, '{32'h8000_0001, 5'd1,  ROT_LEFT},  32'h0000_0003};
    vecs[1] = '{2, '{32'h1234_5678, 5'd4,  ROT_RIGHT}, 32'h8123_4567};
    vecs[2] = '{1, '{32'h1234_5678, 5'd0,  ROT_LEFT},  32'h1234_5678};
    vecs[3] = '{3, '{32'h0000_0001, 5'd31, ROT_LEFT},  32'h8000_0000};
    vecs[4] = '{0, '{32'h0000_0001, 5'd31, ROT_RIGHT}, 32'h0000_0002};
    vecs[5] = '{1, '{32'hA5A5_0000, 5'd16, ROT_LEFT},  32'h0000_A5A5};
    vecs[6] = '{2, '{32'h8000_0000, 5'd1,  ROT_LEFT},  32'h0000_0001};
    vecs[7] = '{3, '{32'hDEAD_BEEF, 5'd8,  ROT_RIGHT}, 32'hEFDE_ADBE};
    rr_seq   = '{0, 1, 2, 3, 0, 1};
    wrap_seq = '{3, 1, 3};

    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = NREQ - 1; m_cnt = 0;
    bus.req_valid = '0; bus.req_num = '0; bus.req_amt = '0; bus.req_lr = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // All requesters valid, downstream always ready: strict rotation, no bubbles.
    for (int i = 0; i < NREQ; i++) begin
      c = '{32'h1000_0000 * (i + 1) + i, 5'(i * 3), rot_dir_t'(i % 2)};
      set_req(i, 1'b1, c);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_id", 64'(bus.resp_id), 64'(rr_seq[k]));
      chk("rr_valid", 64'(bus.resp_valid), 64'd1);
    end
    clear_reqs();
    cycle();

    // Single-requester vectors
    for (int v = 0; v < 8; v++) begin
      clear_reqs();
      set_req(vecs[v].id, 1'b1, vecs[v].cmd);
      cycle();
      chk("vec_data", 64'(bus.resp_data), 64'(vecs[v].exp));
      chk("vec_id",   64'(bus.resp_id),   64'(vecs[v].id));
    end
    clear_reqs();
    cycle();

    // Stall five cycles with a result pending and requester 1 waiting.
    set_req(1, 1'b1, '{32'h0F0F_1234, 5'd12, ROT_LEFT});
    cycle();
    set_req(1, 1'b1, '{32'hCAFE_0001, 5'd3, ROT_RIGHT});
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_data",  64'(bus.resp_data), 64'(rot_ref(32'h0F0F_1234, 12, 1'b0)));
    end
`ifdef SHIFT_ARB_PERF_EN
    chk("stall_cnt5", 64'(stall_cnt), 64'd5);
`endif
    bus.resp_ready = 1'b1;
    #1;
    chk("release_ready", 64'(bus.req_ready), 64'b0010);
    cycle();
    chk("release_data", 64'(bus.resp_data), 64'(rot_ref(32'hCAFE_0001, 3, 1'b1)));

    // last_grant is 1; requests on 1 and 3 only must alternate 3,1,3.
    clear_reqs();
    set_req(1, 1'b1, '{32'h0000_0011, 5'd1, ROT_LEFT});
    set_req(3, 1'b1, '{32'h0000_0033, 5'd2, ROT_LEFT});
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wrap_id", 64'(bus.resp_id), 64'(wrap_seq[k]));
    end

    // Reset while a result is stalled; first grant afterwards goes to 0.
    clear_reqs();
    set_req(2, 1'b1, '{32'h0000_00FF, 5'd4, ROT_LEFT});
    cycle();
    bus.resp_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
    rst = 1'b1;
    cycle();
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, '{32'h0000_0100 << i, 5'(i), ROT_LEFT});
    cycle();
    chk("post_rst_id", 64'(bus.resp_id), 64'd0);

    // Random traffic; payloads only change when idle or just accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || (m_fire && m_win == i)) begin
          set_req(i, 1'($urandom_range(0, 9) < 6),
                  '{$urandom, 5'($urandom_range(0, 31)), rot_dir_t'($urandom_range(0, 1))});
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
